// File: rtl/trans_byte_serializer_if.sv
// Byte-serializer bundle: 128-bit transaction input pulse plus the valid/ready byte stream.
// The master modport drives transactions and sink ready. The slave modport is the serializer.
interface trans_byte_serializer_if;
    logic [127:0] data_i;
    logic         valid_i;
    logic [7:0]   byte_o;
    logic         byte_valid_o;
    logic         byte_ready_i;
    logic         sof_o;
    logic         last_o;

    modport master (
        output data_i, valid_i, byte_ready_i,
        input  byte_o, byte_valid_o, sof_o, last_o
    );

    modport slave (
        input  data_i, valid_i, byte_ready_i,
        output byte_o, byte_valid_o, sof_o, last_o
    );
endinterface

// File: rtl/trans_byte_serializer.sv
// Buffers validated 128-bit transactions in a FIFO and streams each one out MSB-first as 16 bytes.
// Latency: a word sampled at edge N into an empty FIFO while idle is popped at N+1, so byte 0 is valid after N+1.
// Throughput is 1 byte/cycle. The byte stream stalls on byte_ready_i; input cannot stall, so a word arriving when full is dropped and counted.
module trans_byte_serializer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    trans_byte_serializer_if.slave  bus,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    overflow_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [127:0]     shreg_q, shreg_d;
    logic             vld_q, vld_d;
    logic             sof_q, sof_d;
    logic             last_q, last_d;

    logic [127:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             overflow_q;
    logic [CNT_W-1:0] drop_cnt_q;

    logic fifo_empty, fifo_full, accept, pop, push, drop;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (PTR_W+1)'(DEPTH));
    assign accept     = vld_q & bus.byte_ready_i;
    // A pop on the same edge frees a slot, so a full FIFO can still take the incoming word.
    assign push       = bus.valid_i & (~fifo_full | pop);
    assign drop       = bus.valid_i & ~push;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        vld_d   = vld_q;
        sof_d   = sof_q;
        last_d  = last_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                    idx_d   = 4'd0;
                    shreg_d = mem[rd_ptr_q];
                    vld_d   = 1'b1;
                    sof_d   = 1'b1;
                    last_d  = 1'b0;
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx_q != 4'd15) begin
                        // Shift so byte_o always comes straight from the top register byte.
                        idx_d   = idx_q + 4'd1;
                        shreg_d = {shreg_q[119:0], 8'h00};
                        sof_d   = 1'b0;
                        last_d  = (idx_q == 4'd14);
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        idx_d   = 4'd0;
                        shreg_d = mem[rd_ptr_q];
                        sof_d   = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        shreg_d = '0;
                        vld_d   = 1'b0;
                        sof_d   = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            shreg_q <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (PTR_W+1)'(1);
                2'b01:   level_q <= level_q - (PTR_W+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.byte_o       = shreg_q[127:120];
    assign bus.byte_valid_o = vld_q;
    assign bus.sof_o        = sof_q;
    assign bus.last_o       = last_q;
    assign level_o          = level_q;
    assign overflow_o       = overflow_q;
    assign drop_cnt_o       = drop_cnt_q;
endmodule

// File: tb/tb_trans_byte_serializer.sv
// Randomized scoreboard bench for trans_byte_serializer: each stored transaction queues its 16 expected bytes,
// and a monitor pops and compares every accepted byte and checks outputs hold steady while stalled.
module tb_trans_byte_serializer;
    localparam int DEPTH = 8;
    localparam int CNT_W = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_cnt;

    trans_byte_serializer_if bus();

    trans_byte_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .level_o    (level),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    int         outstanding = 0;
    int         txn_out = 0;
    int         ready_mode = 0;
    logic [9:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference: a stored transaction appears as bytes 127:120 first, down to 7:0, sof on the first, last on the 16th.
    task automatic expect_txn(input logic [127:0] d);
        for (int i = 0; i < 16; i++) sb.push_back({i == 0, i == 15, d[127-8*i -: 8]});
        outstanding++;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || bus.byte_valid_o) && n < budget) begin
            step();
            n++;
        end
        check(name, (sb.size() != 0) || bus.byte_valid_o, 0);
    endtask

    // Sink ready generator: 0 = held low, 1 = held high, otherwise random.
    initial begin
        bus.byte_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.byte_ready_i = 1'b0;
                1:       bus.byte_ready_i = 1'b1;
                default: bus.byte_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples between the ready update and the next rising edge.
    initial begin
        bit         stall_prev = 1'b0;
        logic [9:0] prev_out = '0;
        logic [9:0] cur;
        logic [9:0] exp;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                cur = {bus.sof_o, bus.last_o, bus.byte_o};
                if (stall_prev) check("stall_hold", cur, prev_out);
                if (bus.byte_valid_o && bus.byte_ready_i) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_byte: got %0h, expected no byte", cur);
                    end else begin
                        exp = sb.pop_front();
                        check("byte_stream", cur, exp);
                    end
                    if (bus.last_o) begin
                        outstanding--;
                        txn_out++;
                    end
                end
                stall_prev = bus.byte_valid_o && !bus.byte_ready_i;
                prev_out = cur;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int peak, first, lastc, bad, found, exp_drop;

        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        step();
        step();
        check("rst_byte_valid", bus.byte_valid_o, 0);
        check("rst_byte", bus.byte_o, 0);
        check("rst_sof_last", {bus.sof_o, bus.last_o}, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        step();

        // Single transaction, ready high, latency check.
        ready_mode = 1;
        step();
        d = 128'h00112233445566778899AABBCCDDEEFF;
        bus.data_i = d;
        bus.valid_i = 1'b1;
        expect_txn(d);
        step();
        bus.valid_i = 1'b0;
        check("s1_level_after_write", level, 1);
        check("s1_valid_before_pop", bus.byte_valid_o, 0);
        step();
        check("s1_byte0_valid", bus.byte_valid_o, 1);
        check("s1_byte0", {bus.sof_o, bus.last_o, bus.byte_o}, {2'b10, 8'h00});
        check("s1_level_after_pop", level, 0);
        wait_drain("s1_drain", 40);

        // Same pattern with random ready.
        ready_mode = 2;
        bus.data_i = d;
        bus.valid_i = 1'b1;
        expect_txn(d);
        step();
        bus.valid_i = 1'b0;
        wait_drain("s3_drain", 300);

        // Three back-to-back words, ready high: 48 contiguous bytes.
        ready_mode = 1;
        step();
        peak = 0;
        first = -1;
        lastc = -1;
        for (int c = 0; c < 200; c++) begin
            if (c < 3) begin
                d = rand128();
                bus.data_i = d;
                bus.valid_i = 1'b1;
                expect_txn(d);
            end else begin
                bus.valid_i = 1'b0;
            end
            step();
            if (int'(level) > peak) peak = int'(level);
            if (bus.byte_valid_o) begin
                if (first < 0) first = c;
                lastc = c;
            end
            if (c >= 3 && sb.size() == 0 && !bus.byte_valid_o) break;
        end
        check("s2_peak_level", peak, 2);
        check("s2_contiguous_span", lastc - first + 1, 48);
        check("s2_drain", sb.size(), 0);

        // Random traffic kept below FIFO capacity with random ready.
        ready_mode = 2;
        for (int c = 0; c < 400; c++) begin
            if (outstanding < DEPTH && $urandom_range(0, 2) == 0) begin
                d = rand128();
                bus.data_i = d;
                bus.valid_i = 1'b1;
                expect_txn(d);
            end else begin
                bus.valid_i = 1'b0;
            end
            step();
        end
        bus.valid_i = 1'b0;
        wait_drain("rand_drain", 2000);
        check("rand_no_drop", drop_cnt, 0);
        check("rand_no_overflow", overflow, 0);

        // Stalled sink, 11 back-to-back words: capacity is DEPTH plus one in the shift register.
        ready_mode = 0;
        step();
        step();
        txn_out = 0;
        for (int i = 0; i < 11; i++) begin
            d = rand128();
            bus.data_i = d;
            bus.valid_i = 1'b1;
            if (i < DEPTH + 1) expect_txn(d);
            step();
        end
        bus.valid_i = 1'b0;
        step();
        check("s4_level_full", level, DEPTH);
        check("s4_overflow", overflow, 1);
        check("s4_drop_cnt", drop_cnt, 2);
        check("s4_first_held", {bus.byte_valid_o, bus.sof_o}, 2'b11);
        ready_mode = 2;
        wait_drain("s4_drain", 1500);
        check("s4_txn_out", txn_out, DEPTH + 1);

        // Full FIFO, new word on the same edge as the last-byte pop: no drop.
        ready_mode = 0;
        step();
        step();
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = rand128();
            bus.data_i = d;
            bus.valid_i = 1'b1;
            expect_txn(d);
            step();
        end
        bus.valid_i = 1'b0;
        step();
        check("s5_level_full", level, DEPTH);
        ready_mode = 1;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            step();
            if (bus.byte_valid_o && bus.last_o && bus.byte_ready_i) found = 1;
        end
        check("s5_last_seen", found, 1);
        d = rand128();
        bus.data_i = d;
        bus.valid_i = 1'b1;
        expect_txn(d);
        step();
        bus.valid_i = 1'b0;
        check("s5_level_stays_full", level, DEPTH);
        check("s5_drop_cnt_unchanged", drop_cnt, 2);
        check("s5_zero_bubble", {bus.byte_valid_o, bus.sof_o}, 2'b11);
        wait_drain("s5_drain", 600);

        // Drop counter saturation: three more drops on top of two.
        ready_mode = 0;
        step();
        step();
        for (int i = 0; i < DEPTH + 4; i++) begin
            d = rand128();
            bus.data_i = d;
            bus.valid_i = 1'b1;
            if (i < DEPTH + 1) expect_txn(d);
            step();
        end
        bus.valid_i = 1'b0;
        step();
        exp_drop = (2 + 3 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : 2 + 3;
        check("sat_drop_cnt", drop_cnt, exp_drop);
        check("sat_overflow", overflow, 1);
        ready_mode = 1;
        wait_drain("sat_drain", 600);

        // Reset while byte 7 is presented.
        ready_mode = 1;
        step();
        step();
        d = rand128();
        bus.data_i = d;
        bus.valid_i = 1'b1;
        expect_txn(d);
        step();
        bus.valid_i = 1'b0;
        step();
        for (int k = 0; k < 7; k++) step();
        check("s6_byte7", {bus.sof_o, bus.last_o, bus.byte_o}, {2'b00, d[71:64]});
        rst_n = 1'b0;
        #1;
        check("s6_rst_valid", bus.byte_valid_o, 0);
        check("s6_rst_byte", {bus.sof_o, bus.last_o, bus.byte_o}, 0);
        check("s6_rst_level", level, 0);
        check("s6_rst_status", {overflow, drop_cnt}, 0);
        sb.delete();
        outstanding = 0;
        step();
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.byte_valid_o) bad++;
        end
        check("s6_idle_after_reset", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
